// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, four-state debounce FSM,
// registered level, edge pulses, toggle and wrapping press counter.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int PCNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_in,
  output logic              btn_level,
  output logic              btn_rise,
  output logic              btn_fall,
  output logic              toggle,
  output logic [PCNT_W-1:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  state_t     state;
  logic [CNT_W-1:0] cnt;

  // btn_in is asynchronous; only sync2 may be observed by the FSM.
  // NOTE: registers are updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE_LOW;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
      toggle    <= 1'b0;
      press_cnt <= '0;
    end else begin
      // Pulses are cleared every cycle and only set on the commit edge.
      btn_rise <= 1'b0;
      btn_fall <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (sync2) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync2) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE_HIGH;
            btn_level <= 1'b1;
            btn_rise  <= 1'b1;
            toggle    <= ~toggle;
            press_cnt <= press_cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!sync2) begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (sync2) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE_LOW;
            btn_level <= 1'b0;
            btn_fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with DEBOUNCE_CYCLES=8: stimulus
// pushes expected edge events, a negedge monitor pops and compares them.
module tb_button_debouncer;

  localparam int D = 8;
  localparam int LAT = D + 2;

  typedef struct {
    logic        rise;
    int unsigned at_edge;
    logic [7:0]  press;
    logic        tog;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       btn_level;
  logic       btn_rise;
  logic       btn_fall;
  logic       toggle;
  logic [7:0] press_cnt;

  int unsigned edge_cnt = 0;
  int unsigned rises_seen = 0;
  int          n_total = 0;
  int          n_pass = 0;
  ev_t         exp_q[$];
  logic [7:0]  exp_press = '0;
  logic        exp_tog = 1'b0;

  button_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4),
    .PCNT_W         (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall),
    .toggle   (toggle),
    .press_cnt(press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
  endtask

  task automatic push_rise(input int unsigned k);
    ev_t e;
    exp_press = exp_press + 8'd1;
    exp_tog   = ~exp_tog;
    e.rise = 1'b1; e.at_edge = k + LAT; e.press = exp_press; e.tog = exp_tog;
    exp_q.push_back(e);
  endtask

  task automatic push_fall(input int unsigned k);
    ev_t e;
    e.rise = 1'b0; e.at_edge = k + LAT; e.press = exp_press; e.tog = exp_tog;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; a held level of 'hold' cycles each way always commits.
  task automatic clean_press(input int hold);
    btn_in = 1'b1;
    push_rise(edge_cnt + 1);
    repeat (hold) @(negedge clk);
    btn_in = 1'b0;
    push_fall(edge_cnt + 1);
    repeat (hold) @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_press = '0;
    exp_tog   = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: every pulse on btn_rise/btn_fall must match the queue head.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (btn_rise || btn_fall)) begin
      if (btn_rise) rises_seen++;
      check("rise_fall_exclusive", 32'(btn_rise & btn_fall), 32'd0);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_event: rise=%0b fall=%0b at edge %0d, none expected",
                 btn_rise, btn_fall, edge_cnt);
      end else begin
        e = exp_q.pop_front();
        check("event_kind_rise", 32'(btn_rise), 32'(e.rise));
        check("event_edge", 32'(edge_cnt), 32'(e.at_edge));
        check("event_level", 32'(btn_level), 32'(e.rise));
        check("event_press_cnt", 32'(press_cnt), 32'(e.press));
        check("event_toggle", 32'(toggle), 32'(e.tog));
      end
    end
    if (exp_q.size() > 0 && edge_cnt > exp_q[0].at_edge) begin
      n_total++;
      $display("FAIL missing_event: expected %s at edge %0d, none by edge %0d",
               exp_q[0].rise ? "rise" : "fall", exp_q[0].at_edge, edge_cnt);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    int unsigned rises_before;
    rst_n  = 1'b0;
    btn_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1. Reset state with idle input.
    repeat (20) @(negedge clk);
    check("reset_level", 32'(btn_level), 32'd0);
    check("reset_rise", 32'(btn_rise), 32'd0);
    check("reset_fall", 32'(btn_fall), 32'd0);
    check("reset_toggle", 32'(toggle), 32'd0);
    check("reset_press_cnt", 32'(press_cnt), 32'd0);

    // 2. Clean press and release, with exact latency probes.
    btn_in = 1'b1;
    k = edge_cnt + 1;
    push_rise(k);
    repeat (LAT) @(negedge clk);
    check("press_level_before_commit", 32'(btn_level), 32'd0);
    @(negedge clk);
    check("press_level_at_commit", 32'(btn_level), 32'd1);
    check("press_rise_at_commit", 32'(btn_rise), 32'd1);
    @(negedge clk);
    check("press_rise_one_cycle", 32'(btn_rise), 32'd0);
    check("press_toggle", 32'(toggle), 32'd1);
    check("press_cnt_1", 32'(press_cnt), 32'd1);
    repeat (18) @(negedge clk);
    btn_in = 1'b0;
    k = edge_cnt + 1;
    push_fall(k);
    repeat (LAT) @(negedge clk);
    check("release_level_before_commit", 32'(btn_level), 32'd1);
    @(negedge clk);
    check("release_level_at_commit", 32'(btn_level), 32'd0);
    check("release_fall_at_commit", 32'(btn_fall), 32'd1);
    check("release_toggle_held", 32'(toggle), 32'd1);
    repeat (20) @(negedge clk);

    // 3. Bounce every 3 cycles, then settle high.
    for (int i = 0; i < 14; i++) begin
      btn_in = (i % 2 == 0);
      repeat (3) @(negedge clk);
    end
    check("bounce_no_level", 32'(btn_level), 32'd0);
    check("bounce_press_unchanged", 32'(press_cnt), 32'd1);
    btn_in = 1'b1;
    push_rise(edge_cnt + 1);
    repeat (20) @(negedge clk);
    btn_in = 1'b0;
    push_fall(edge_cnt + 1);
    repeat (20) @(negedge clk);

    // 4. Glitches of 1 and D sampled cycles must be ignored.
    btn_in = 1'b1;
    @(negedge clk);
    btn_in = 1'b0;
    repeat (15) @(negedge clk);
    btn_in = 1'b1;
    repeat (D) @(negedge clk);
    btn_in = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch_level", 32'(btn_level), 32'd0);
    check("glitch_press_cnt", 32'(press_cnt), 32'(exp_press));

    // 5. 256 presses from a fresh reset wrap the counter.
    reset_pulse();
    rises_before = rises_seen;
    for (int i = 0; i < 256; i++) clean_press(12);
    check("wrap_press_cnt", 32'(press_cnt), 32'd0);
    check("wrap_toggle", 32'(toggle), 32'd0);
    check("wrap_rise_count", rises_seen - rises_before, 32'd256);

    // 6. Asynchronous reset five cycles into WAIT_HIGH.
    clean_press(12);
    btn_in = 1'b1;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_toggle", 32'(toggle), 32'd0);
    check("async_rst_press_cnt", 32'(press_cnt), 32'd0);
    check("async_rst_level", 32'(btn_level), 32'd0);
    exp_press = '0;
    exp_tog   = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_rise(edge_cnt + 1);
    repeat (LAT + 1) @(negedge clk);
    check("held_at_release_level", 32'(btn_level), 32'd1);
    check("held_at_release_press_cnt", 32'(press_cnt), 32'd1);
    repeat (10) @(negedge clk);
    btn_in = 1'b0;
    push_fall(edge_cnt + 1);
    repeat (20) @(negedge clk);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
